sync_fifo_prog: RTL and testbench

Parametrised single-clock FIFO. It is the next-generation replacement for the team's fixed 8x16 FIFO core.
- Adds runtime-programmable almost-full/almost-empty thresholds, a synchronous flush, sticky overflow/underflow error flags and a registered read-valid strobe.
- Sits between producer/consumer datapaths inside one clock domain.

---
 rtl/sync_fifo_pkg.sv | 22 ++
 rtl/sync_fifo_prog_ram.sv | 28 ++
 rtl/sync_fifo_prog.sv | 149 ++++++++++++++
 tb/tb_sync_fifo_prog.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the programmable synchronous FIFO family.
package sync_fifo_pkg;

   localparam int FIFO_DATA_W_DEF = 8;
   localparam int FIFO_DEPTH_DEF  = 16;
   localparam int FIFO_AF_DEF     = 12;
   localparam int FIFO_AE_DEF     = 4;

   // Ceiling log2 for tools without a working $clog2 in parameter context.
   function automatic int fifo_clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sync_fifo_prog_ram.sv
// fifo_ram: DEPTH x DATA_W register array, synchronous write, asynchronous read.
module fifo_ram
   import sync_fifo_pkg::*;
#(
   parameter int DATA_W = FIFO_DATA_W_DEF,
   parameter int DEPTH  = FIFO_DEPTH_DEF,
   localparam int AW    = fifo_clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Storage write; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/empty thresholds, flush and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads are registered.
module sync_fifo_prog
   import sync_fifo_pkg::*;
#(
   parameter int DATA_W = FIFO_DATA_W_DEF,
   parameter int DEPTH  = FIFO_DEPTH_DEF,
   localparam int AW    = fifo_clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              asyn_rst,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic              flush,
   input  logic              clr_err,
   input  logic [AW:0]       af_level,
   input  logic [AW:0]       ae_level,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic [AW:0]       count,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              overflow,
   output logic              underflow
);

   localparam int            CW      = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              wr_acc_s, rd_acc_s;
   logic              ovf_set_s, unf_set_s;
   logic [DATA_W-1:0] ram_rdata_s;

   fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc_s),
      .waddr (wr_ptr_q),
      .wdata (wr_data),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata_s)
   );

   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == {CW{1'b0}});
   assign almost_full  = (count_q >= af_level);
   assign almost_empty = (count_q <= ae_level);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // Request acceptance; flush swallows both requests without flagging errors.
   always_comb begin
      rd_acc_s  = rd_en & ~empty & ~flush;
      wr_acc_s  = wr_en & (~full | rd_acc_s) & ~flush;
      ovf_set_s = wr_en & ~wr_acc_s & ~flush;
      unf_set_s = rd_en & ~rd_acc_s & ~flush;
   end

   // Pointer, occupancy and sticky-error next state; a new error beats clr_err.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = ovf_set_s | (overflow_q & ~clr_err);
      underflow_d = unf_set_s | (underflow_q & ~clr_err);
      if (flush) begin
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge clk or posedge asyn_rst) begin
      if (asyn_rst) begin
         wr_ptr_q    <= {AW{1'b0}};
         rd_ptr_q    <= {AW{1'b0}};
         count_q     <= {CW{1'b0}};
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

`ifdef FIFO_FWFT_EN
   assign rd_data  = ram_rdata_s;
   assign rd_valid = ~empty;
`else
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;

   // Registered read port: data captured on an accepted pop, held otherwise.
   always_comb begin
      rd_valid_d = rd_acc_s;
      if (rd_acc_s) begin
         rd_data_d = ram_rdata_s;
      end else begin
         rd_data_d = rd_data_q;
      end
   end

   // Read output registers.
   always_ff @(posedge clk or posedge asyn_rst) begin
      if (asyn_rst) begin
         rd_data_q  <= {DATA_W{1'b0}};
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench for sync_fifo_prog: expected words queued at write, monitor pops on reads.
module tb_sync_fifo_prog;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int AW     = 4;

   logic              clk;
   logic              asyn_rst;
   logic [DATA_W-1:0] wr_data;
   logic              wr_en;
   logic              rd_en;
   logic              flush;
   logic              clr_err;
   logic [AW:0]       af_level;
   logic [AW:0]       ae_level;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic [AW:0]       count;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic              overflow;
   logic              underflow;

   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0] exp_q [$];

   sync_fifo_prog #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .asyn_rst     (asyn_rst),
      .wr_data      (wr_data),
      .wr_en        (wr_en),
      .rd_en        (rd_en),
      .flush        (flush),
      .clr_err      (clr_err),
      .af_level     (af_level),
      .ae_level     (ae_level),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every presented/popped word must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!asyn_rst) begin
`ifdef FIFO_FWFT_EN
         if (rd_valid && rd_en && !flush) begin
`else
         if (rd_valid) begin
`endif
            if (exp_q.size() == 0) begin
               checks = checks + 1;
               errors = errors + 1;
               $display("FAIL rd_unexpected got %0h expected none", rd_data);
            end else begin
               chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   task automatic push(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      step();
      wr_en   = 1'b0;
   endtask

   initial begin
      int n;
      logic [7:0] t1_data [4];
      t1_data = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      asyn_rst = 1'b1;
      wr_data  = 8'h00;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      flush    = 1'b0;
      clr_err  = 1'b0;
      af_level = 5'd12;
      ae_level = 5'd4;
      step();
      step();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_errs", 32'({overflow, underflow}), 32'd0);
      asyn_rst = 1'b0;
      step();

      // Test 1: basic order and one-cycle read latency.
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(t1_data[i]);
         push(t1_data[i]);
      end
      chk("t1_count4", 32'(count), 32'd4);
      rd_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
`ifndef FIFO_FWFT_EN
         chk("t1_rd_valid", 32'(rd_valid), 32'd1);
`endif
      end
      rd_en = 1'b0;
      chk("t1_count0", 32'(count), 32'd0);
      chk("t1_empty", 32'(empty), 32'd1);
      step();

      // Test 2: thresholds, full and overflow.
      n = 0;
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back(8'(8'h10 + i));
         push(8'(8'h10 + i));
         n = n + 1;
         chk("t2_count", 32'(count), 32'(n));
         chk("t2_almost_empty", 32'(almost_empty), (n <= 4) ? 32'd1 : 32'd0);
         chk("t2_almost_full", 32'(almost_full), (n >= 12) ? 32'd1 : 32'd0);
         chk("t2_full", 32'(full), (n == 16) ? 32'd1 : 32'd0);
      end
      push(8'h99);
      chk("t2_overflow", 32'(overflow), 32'd1);
      chk("t2_count_ovf", 32'(count), 32'd16);

      // Test 3: simultaneous read/write while full.
      exp_q.push_back(8'hEE);
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      wr_data = 8'hEE;
      step();
      wr_en = 1'b0;
      rd_en = 1'b0;
      chk("t3_count", 32'(count), 32'd16);
      chk("t3_overflow_held", 32'(overflow), 32'd1);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("t3_clr_overflow", 32'(overflow), 32'd0);
      rd_en = 1'b1;
      for (int i = 0; i < 16; i++) step();
      rd_en = 1'b0;
      chk("t3_empty", 32'(empty), 32'd1);
      chk("t3_no_underflow", 32'(underflow), 32'd0);
      step();
      chk("t3_drained", 32'(exp_q.size()), 32'd0);

      // Test 4: read+write on empty.
      exp_q.push_back(8'hFF);
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      wr_data = 8'hFF;
      step();
      wr_en = 1'b0;
      rd_en = 1'b0;
      chk("t4_underflow", 32'(underflow), 32'd1);
`ifndef FIFO_FWFT_EN
      chk("t4_rd_valid", 32'(rd_valid), 32'd0);
`endif
      chk("t4_count", 32'(count), 32'd1);
      rd_en = 1'b1;
      step();
      rd_en   = 1'b0;
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("t4_clr_underflow", 32'(underflow), 32'd0);
      chk("t4_empty", 32'(empty), 32'd1);

      // Test 5: flush priority, then async reset mid-burst.
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(8'(8'h20 + i));
         push(8'(8'h20 + i));
      end
      chk("t5_count6", 32'(count), 32'd6);
      flush   = 1'b1;
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      wr_data = 8'h77;
      step();
      flush = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      exp_q.delete();
      chk("t5_flush_count", 32'(count), 32'd0);
      chk("t5_flush_empty", 32'(empty), 32'd1);
      chk("t5_flush_errs", 32'({overflow, underflow}), 32'd0);
      chk("t5_flush_rd_valid", 32'(rd_valid), 32'd0);
      wr_en = 1'b1;
      rd_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(8'(8'h31 + i));
         wr_data = 8'(8'h31 + i);
         step();
      end
      wr_en = 1'b0;
      rd_en = 1'b0;
      chk("t5_burst_underflow", 32'(underflow), 32'd1);
`ifndef FIFO_FWFT_EN
      chk("t5_burst_rd_data", 32'(rd_data), 32'h32);
`endif
      chk("t5_burst_count", 32'(count), 32'd1);
      #1;
      asyn_rst = 1'b1;
      #1;
      chk("t5_rst_count", 32'(count), 32'd0);
      chk("t5_rst_empty", 32'(empty), 32'd1);
      chk("t5_rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("t5_rst_rd_data", 32'(rd_data), 32'd0);
      chk("t5_rst_errs", 32'({overflow, underflow}), 32'd0);
      exp_q.delete();
      step();
      asyn_rst = 1'b0;
      step();

`ifdef FIFO_FWFT_EN
      // Test 6: fall-through presentation and pop.
      exp_q.push_back(8'h5A);
      push(8'h5A);
      chk("t6_rd_valid", 32'(rd_valid), 32'd1);
      chk("t6_rd_data", 32'(rd_data), 32'h5A);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("t6_empty", 32'(empty), 32'd1);
      chk("t6_rd_valid_off", 32'(rd_valid), 32'd0);
`endif

      step();
      chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
